// File: rtl/fpga_pll_pkg.sv
// fpga_pll_pkg: shared FSM state type and counter width helper for the PLL supervisor
package fpga_pll_pkg;
  typedef enum logic [2:0] {S_RESET, S_WAIT, S_RELEASE, S_RUN, S_FAIL} state_t;
  function automatic int clogw(input int v);
    return $clog2(v + 1);
  endfunction
endpackage

// File: rtl/fpga_sync_bit.sv
// fpga_sync_bit: async-reset multi-flop synchroniser for a single bit
module fpga_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fpga_pll_supervisor.sv
// fpga_pll_supervisor: drives MMCM reset, qualifies lock with retry, and releases
// reset channels LSB first with a fixed stagger
module fpga_pll_supervisor
  import fpga_pll_pkg::*;
#(
  parameter int NUM_RST      = 3,
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int LOCK_STABLE  = 16,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk_in,
  input  logic                          areset,
  input  logic                          pll_lock,
  input  logic                          soft_rst,
  output logic                          pll_rst,
  output logic [NUM_RST-1:0]            rst_out,
  output logic                          ready,
  output logic                          fail,
  output logic                          lock_lost,
  output logic [clogw(MAX_RETRY)-1:0]   retry_cnt
);
  localparam int CW = clogw(RST_PULSE > LOCK_TIMEOUT ? RST_PULSE : LOCK_TIMEOUT);
  localparam int SW = clogw(LOCK_STABLE);
  localparam int GW = clogw(STAGGER);
  localparam int HW = clogw(NUM_RST);
  localparam int RW = clogw(MAX_RETRY);
  localparam logic [CW-1:0] PULSE_END = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TMO       = CW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB       = SW'(LOCK_STABLE);
  localparam logic [GW-1:0] STG_END   = GW'(STAGGER - 1);
  localparam logic [HW-1:0] CH_LAST   = HW'(NUM_RST - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        stab_q, stab_d;
  logic [GW-1:0]        stg_q, stg_d;
  logic [HW-1:0]        ch_q, ch_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0]   rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;
  logic                 lost_q, lost_d;
  logic                 lock_s;
  fpga_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk_in),
    .rst (areset),
    .d   (pll_lock),
    .q   (lock_s)
  );
  always_ff @(posedge clk_in or posedge areset)
    if (areset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      stab_q    <= '0;
      stg_q     <= '0;
      ch_q      <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      stg_q     <= stg_d;
      ch_q      <= ch_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stab_d  = '0;
    stg_d   = stg_q;
    ch_d    = ch_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (soft_rst) begin
      state_d = S_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PULSE_END) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          cnt_d  = cnt_q + 1'b1;
          stab_d = lock_s ? stab_q + 1'b1 : '0;
          // a lock qualifying on the timeout cycle still counts as a success
          if (stab_d == STB) begin
            state_d = (NUM_RST == 1) ? S_RUN : S_RELEASE;
            stg_d   = '0;
            ch_d    = '0;
          end else if (cnt_d == TMO) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_RESET;
            cnt_d   = '0;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state_d = S_RESET;
            lost_d  = 1'b1;
          end else if (state_q == S_RELEASE) begin
            stg_d = stg_q + 1'b1;
            if (stg_q == STG_END) begin
              stg_d   = '0;
              ch_d    = ch_q + 1'b1;
              state_d = (ch_d == CH_LAST) ? S_RUN : S_RELEASE;
            end
          end
        end
        default: ;
      endcase
    end
    if (state_d == S_RUN) retry_d = '0;
  end
  // outputs are registered from the next state so they align with the state change
  always_comb begin
    pll_rst_d = state_d == S_RESET;
    ready_d   = state_d == S_RUN;
    fail_d    = state_d == S_FAIL;
    for (int i = 0; i < NUM_RST; i++)
      rst_out_d[i] = !((state_d == S_RELEASE || state_d == S_RUN) && ch_d >= HW'(i));
  end
  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_fpga_pll_supervisor.sv
// tb_fpga_pll_supervisor: directed scenarios for the PLL supervisor with hand-computed cycle counts
module tb_fpga_pll_supervisor;
  logic       clk_in = 1'b0;
  logic       areset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst, ready, fail, lock_lost;
  logic [2:0] rst_out;
  logic [1:0] retry_cnt;
  int         checks = 0;
  int         errors = 0;
  int         n;
  fpga_pll_supervisor #(
    .NUM_RST(3), .RST_PULSE(4), .LOCK_TIMEOUT(100), .LOCK_STABLE(8),
    .STAGGER(2), .MAX_RETRY(3), .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk_in),
    .areset    (areset),
    .pll_lock  (pll_lock),
    .soft_rst  (soft_rst),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge clk_in);
    #1;
  endtask
  function automatic logic sig(input int sel);
    case (sel)
      0: return pll_rst;
      1: return rst_out[0];
      2: return fail;
      3: return ready;
      default: return rst_out == 3'b100;
    endcase
  endfunction
  // cycles until the selected signal reaches val, capped so a stuck DUT still ends the run
  task automatic wait_for(input int sel, input logic val, output int k);
    k = 0;
    while (sig(sel) !== val && k < 300) begin
      cyc(1);
      k++;
    end
  endtask
  initial begin
    cyc(3);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_rst_out", rst_out, 3'b111);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_retry", retry_cnt, 0);
    // normal lock; counts run from the pll_lock edge, sync latency included
    areset = 1'b0;
    wait_for(0, 1'b0, n);
    chk("s1_pulse_len", n, 4);
    pll_lock = 1'b1;
    wait_for(1, 1'b0, n);
    chk("s1_release_lat", n, 10);
    chk("s1_rst_out_a", rst_out, 3'b110);
    cyc(1);
    chk("s1_rst_out_b", rst_out, 3'b110);
    cyc(1);
    chk("s1_rst_out_c", rst_out, 3'b100);
    chk("s1_ready_early", ready, 0);
    cyc(2);
    chk("s1_rst_out_d", rst_out, 3'b000);
    chk("s1_ready", ready, 1);
    chk("s1_retry", retry_cnt, 0);
    // lock glitch: 5 synced-high cycles, 1 low, restart
    soft_rst = 1'b1;
    pll_lock = 1'b0;
    cyc(1);
    soft_rst = 1'b0;
    chk("s2_soft_rst_out", rst_out, 3'b111);
    chk("s2_soft_ready", ready, 0);
    chk("s2_soft_pll_rst", pll_rst, 1);
    wait_for(0, 1'b0, n);
    chk("s2_pulse_len", n, 4);
    pll_lock = 1'b1;
    cyc(5);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    wait_for(1, 1'b0, n);
    chk("s2_release_lat", n + 6, 16);
    cyc(4);
    chk("s2_ready", ready, 1);
    // loss of lock in run
    pll_lock = 1'b0;
    cyc(2);
    chk("s4_still_run", {ready, rst_out}, 4'b1000);
    cyc(1);
    chk("s4_rst_out", rst_out, 3'b111);
    chk("s4_ready", ready, 0);
    chk("s4_lock_lost", lock_lost, 1);
    chk("s4_pll_rst", pll_rst, 1);
    wait_for(0, 1'b0, n);
    chk("s4_pulse_len", n, 4);
    pll_lock = 1'b1;
    wait_for(1, 1'b0, n);
    chk("s4_release_lat", n, 10);
    cyc(4);
    chk("s4_relock_ready", ready, 1);
    chk("s4_relock_rst_out", rst_out, 3'b000);
    chk("s4_lost_sticky", lock_lost, 1);
    // areset mid-release
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    chk("s6_soft_keeps_lost", lock_lost, 1);
    wait_for(4, 1'b1, n);
    chk("s6_mid_release", rst_out, 3'b100);
    areset = 1'b1;
    #1;
    chk("s6_rst_out", rst_out, 3'b111);
    chk("s6_pll_rst", pll_rst, 1);
    chk("s6_ready", ready, 0);
    chk("s6_lost_clr", lock_lost, 0);
    chk("s6_retry", retry_cnt, 0);
    cyc(1);
    areset = 1'b0;
    wait_for(0, 1'b0, n);
    chk("s6_pulse_len", n, 4);
    wait_for(3, 1'b1, n);
    chk("s6_ready_lat", n, 12);
    // soft_rst coincides with synced lock drop: no lock_lost
    pll_lock = 1'b0;
    cyc(2);
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    chk("s5_lock_lost", lock_lost, 0);
    chk("s5_rst_out", rst_out, 3'b111);
    chk("s5_ready", ready, 0);
    chk("s5_pll_rst", pll_rst, 1);
    // never lock: retries then fail
    wait_for(0, 1'b0, n);
    chk("s3_pulse0", n, 4);
    for (int r = 1; r <= 2; r++) begin
      wait_for(0, 1'b1, n);
      chk("s3_timeout", n, 100);
      chk("s3_retry", retry_cnt, r);
      wait_for(0, 1'b0, n);
      chk("s3_pulse", n, 4);
    end
    wait_for(2, 1'b1, n);
    chk("s3_fail_lat", n, 100);
    chk("s3_retry_max", retry_cnt, 3);
    chk("s3_fail_pll_rst", pll_rst, 0);
    chk("s3_fail_rst_out", rst_out, 3'b111);
    cyc(5);
    chk("s3_fail_hold", {fail, pll_rst, ready}, 3'b100);
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    chk("s3_soft_fail", fail, 0);
    chk("s3_soft_retry", retry_cnt, 0);
    chk("s3_soft_pll_rst", pll_rst, 1);
    wait_for(0, 1'b0, n);
    chk("s3_soft_pulse", n, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
